obstacle_renderer: RTL
======================

Name: obstacle_renderer

Overview:
Pixel source for the Vga stage. It owns the scrolling cactus obstacles, scoring and dinosaur/obstacle collision detection. Every cycle it converts the Vga scan address (row_addr/col_addr) plus the game state (dinosaur_height, game_status, speed) into the 12-bit colour that feeds Vga d_in. Obstacle motion advances once per video frame.

Parameters:
MAX_OBS, 4, number of obstacle slots
OBS_W, 16, obstacle width in pixels
OBS_H, 32, obstacle height in pixels
GROUND_Y, 400, first row of ground line; obstacles stand on it
DINO_X, 64, dinosaur left column
DINO_W, 32, dinosaur width
DINO_H, 40, dinosaur height
MIN_GAP, 160, minimum scrolled pixels between spawns
SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
vs  in  1  vertical sync from Vga; rising edge marks frame boundary
game_status  in  1  1 = running, 0 = paused
speed  in  4  pixels scrolled per frame
dinosaur_height  in  6  jump height in units of 4 px above ground
row_addr  in  9  current scan row
col_addr  in  10  current scan column
vga_data  out  12  {r[3:0], g[3:0], b[3:0]} to Vga d_in
collision  out  1  sticky hit flag
score  out  16  obstacles passed, saturating

Behaviour:
Clock and reset:
- One clock (CLK). Reset is synchronous and active-high (RST).
- Reset values: all slots invalid, x = 0, score = 0, collision = 0, vga_data = 0, gap_cnt = 0, lfsr = SEED, vs_d = 1.
- vs_d = 1 at reset suppresses a spurious tick if vs is already high.
- RST asserted mid-frame takes effect on the next edge; rendering of the remaining frame shows the cleared scene.

Frame tick:
- tick = vs & ~vs_d, exactly 1 cycle per frame. vs_d is vs registered.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle. Never reaches zero.

Update on tick:
- An update occurs only when tick & game_status & ~collision; otherwise all game state holds. Order within one tick:
  1. Move: for each valid slot, x is 11-bit. If x <= speed, the slot is cleared and score += 1, saturating at 16'hFFFF. Else x -= speed.
  2. Spawn: gap_cnt += speed, saturating at 11 bits. If gap_cnt >= MIN_GAP + lfsr[6:0], a new obstacle is placed at x = 640 in the lowest-index free slot (a slot freed in step 1 counts as free) and gap_cnt = 0. If no slot is free, no spawn occurs and gap_cnt is kept for a retry next tick.
  3. Collision: evaluated on the post-move, post-spawn positions. Hit when, for any valid slot:
     - x < DINO_X + DINO_W, and
     - x + OBS_W > DINO_X, and
     - 4*dinosaur_height < OBS_H.
     A hit sets collision = 1 in the same update. collision stays 1 until RST.
- speed = 0: nothing moves and gap_cnt does not grow.

Geometry:
- Dinosaur rows: GROUND_Y - DINO_H - 4h to GROUND_Y - 4h - 1. Columns: DINO_X to DINO_X + DINO_W - 1.
- Obstacle rows: GROUND_Y - OBS_H to GROUND_Y - 1. Columns: x to x + OBS_W - 1, clipped at col 639.
- Ground rows: GROUND_Y and GROUND_Y + 1.

Rendering:
- Registered output: vga_data in cycle n+1 reflects row_addr/col_addr in cycle n. Fixed latency of 1.
- Priority, highest first:
  - row >= 480 or col >= 640: 12'h000
  - dinosaur: 12'h555, or 12'hF00 when collision = 1
  - obstacle: 12'h0A0
  - ground: 12'h000
  - background: 12'hFFF
- Rendering continues while paused and after a collision; the scene is frozen, not blanked.

Test Plan:
- RST held 2 cycles with vs = 1, then released -> no tick, score = 0, collision = 0; scanning (10,100) gives vga_data = 12'hFFF one cycle later.
- Scan (GROUND_Y, 300) -> 12'h000. Scan (GROUND_Y-10, DINO_X+5) with h = 0 -> 12'h555 after exactly 1 cycle. Scan (480, 0) -> 12'h000.
- game_status = 1, speed = 8, h = 20, run frames -> first spawn at x = 640 once gap_cnt >= 160 + lfsr[6:0]; each tick after spawn x drops by 8; slot clears when x <= 8 and score increments by 1.
- Same run with h = 0 -> collision rises on the first tick where obstacle x < 96 and x + 16 > 64; score and x freeze afterwards; dinosaur pixels read 12'hF00.
- game_status = 0 for 10 frames mid-run -> x, score and gap_cnt unchanged; resuming continues from the held values.
- Force 4 live slots with spawn due -> no spawn and gap_cnt kept; on the tick slot 0 clears, it is reused at x = 640 in that same tick. Preload score = 16'hFFFF and pass an obstacle -> score stays 16'hFFFF.

Source files
------------

// File: rtl/obstacle_renderer.sv
// Scrolling cactus obstacles, scoring and dinosaur collision for the Vga pixel stream.
// Game state advances once per frame; pixel colour is registered with one cycle of latency.
module obstacle_renderer #(
  parameter int          MAX_OBS  = 4,
  parameter int          OBS_W    = 16,
  parameter int          OBS_H    = 32,
  parameter int          GROUND_Y = 400,
  parameter int          DINO_X   = 64,
  parameter int          DINO_W   = 32,
  parameter int          DINO_H   = 40,
  parameter int          MIN_GAP  = 160,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        vs,
  input  logic        game_status,
  input  logic [3:0]  speed,
  input  logic [5:0]  dinosaur_height,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  output logic [11:0] vga_data,
  output logic        collision,
  output logic [15:0] score
);

  localparam int IW = (MAX_OBS > 1) ? $clog2(MAX_OBS) : 1;
  localparam logic [10:0] SPAWN_X = 11'd640;

  logic               vs_d;
  logic               tick;
  logic               update;
  logic [15:0]        lfsr;
  logic [10:0]        gap_cnt;
  logic [MAX_OBS-1:0] valid;
  logic [10:0]        obs_x [MAX_OBS];

  logic [MAX_OBS-1:0] valid_nx;
  logic [10:0]        x_nx [MAX_OBS];
  logic [15:0]        score_nx;
  logic [10:0]        gap_nx;
  logic [11:0]        gap_sum;
  logic [10:0]        gap_sat;
  logic               spawn_due;
  logic               free_found;
  logic [IW-1:0]      free_idx;
  logic               hit;

  logic [9:0]         dino_row;
  logic               in_view;
  logic               dino_px;
  logic               obs_px;
  logic               ground_px;
  logic [11:0]        pixel;

  assign tick   = vs & ~vs_d;
  assign update = tick & game_status & ~collision;

  // Next game state for one frame update: move, then spawn, then collide on the result.
  always_comb begin
    valid_nx   = valid;
    x_nx       = obs_x;
    score_nx   = score;
    free_found = 1'b0;
    free_idx   = '0;
    hit        = 1'b0;

    for (int i = 0; i < MAX_OBS; i++) begin
      if (valid[i]) begin
        if (obs_x[i] <= {7'd0, speed}) begin
          valid_nx[i] = 1'b0;
          if (score_nx != 16'hFFFF) score_nx = score_nx + 16'd1;
        end else begin
          x_nx[i] = obs_x[i] - {7'd0, speed};
        end
      end
    end

    gap_sum   = {1'b0, gap_cnt} + {8'd0, speed};
    gap_sat   = gap_sum[11] ? 11'h7FF : gap_sum[10:0];
    spawn_due = gap_sat >= (11'(MIN_GAP) + {4'd0, lfsr[6:0]});

    // Descending scan leaves the lowest-index free slot selected.
    for (int i = MAX_OBS - 1; i >= 0; i--) begin
      if (!valid_nx[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end

    gap_nx = gap_sat;
    if (spawn_due && free_found) begin
      valid_nx[free_idx] = 1'b1;
      x_nx[free_idx]     = SPAWN_X;
      gap_nx             = '0;
    end

    for (int i = 0; i < MAX_OBS; i++) begin
      if (valid_nx[i] && (x_nx[i] < 11'(DINO_X + DINO_W)) &&
          (({1'b0, x_nx[i]} + 12'(OBS_W)) > 12'(DINO_X)) &&
          ({dinosaur_height, 2'b00} < 8'(OBS_H)))
        hit = 1'b1;
    end
  end

  // Pixel classification; row + 4h folds the jump offset into a fixed dinosaur band.
  always_comb begin
    dino_row  = {1'b0, row_addr} + {2'b00, dinosaur_height, 2'b00};
    in_view   = (row_addr < 9'd480) && (col_addr < 10'd640);
    dino_px   = (dino_row >= 10'(GROUND_Y - DINO_H)) && (dino_row < 10'(GROUND_Y)) &&
                (col_addr >= 10'(DINO_X)) && (col_addr < 10'(DINO_X + DINO_W));
    ground_px = (row_addr == 9'(GROUND_Y)) || (row_addr == 9'(GROUND_Y + 1));
    obs_px    = 1'b0;
    for (int i = 0; i < MAX_OBS; i++) begin
      if (valid[i] && (row_addr >= 9'(GROUND_Y - OBS_H)) && (row_addr < 9'(GROUND_Y)) &&
          ({1'b0, col_addr} >= obs_x[i]) &&
          ({2'b00, col_addr} < ({1'b0, obs_x[i]} + 12'(OBS_W))))
        obs_px = 1'b1;
    end

    if (!in_view)       pixel = 12'h000;
    else if (dino_px)   pixel = collision ? 12'hF00 : 12'h555;
    else if (obs_px)    pixel = 12'h0A0;
    else if (ground_px) pixel = 12'h000;
    else                pixel = 12'hFFF;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vs_d      <= 1'b1;
      lfsr      <= SEED;
      gap_cnt   <= '0;
      valid     <= '0;
      score     <= '0;
      collision <= 1'b0;
      vga_data  <= '0;
      for (int i = 0; i < MAX_OBS; i++) obs_x[i] <= '0;
    end else begin
      vs_d     <= vs;
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      vga_data <= pixel;
      if (update) begin
        valid     <= valid_nx;
        score     <= score_nx;
        gap_cnt   <= gap_nx;
        collision <= hit;
        for (int i = 0; i < MAX_OBS; i++) obs_x[i] <= x_nx[i];
      end
    end
  end

endmodule
